// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encoding (same numbering as the TX side)
// and default frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;
  // start + data + stop
  localparam int FRAME_BITS     = DATA_BITS_DEF + 2;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin. Both flops reset to the
// idle-high line level so reset release never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw pin through two flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Oversamples the synchronised line on sample_tick,
// validates the start bit at its midpoint, samples each data and stop bit at
// its midpoint, and returns to IDLE at mid stop bit so a following start bit
// is caught without loss.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | counting to mid start bit, rejecting glitches
// DATA  | sampling DATA_BITS bits, LSB first
// STOP  | sampling stop bit; strobe rx_done or frame_err
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state, state_d;
  logic [TW-1:0]        tick_cnt, tick_d;
  logic [BW-1:0]        bit_cnt, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 done_d, err_d;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_rx),
    .q   (rx_s)
  );

  // State, counters, shift register and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      tick_cnt  <= tick_d;
      bit_cnt   <= bit_d;
      shift_q   <= shift_d;
      rx_data   <= data_d;
      rx_done   <= done_d;
      frame_err <= err_d;
    end
  end

  // Next-state, counter and strobe decode; counters clear on every state entry.
  always_comb begin
    state_d = state;
    tick_d  = tick_cnt;
    bit_d   = bit_cnt;
    shift_d = shift_q;
    data_d  = rx_data;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          tick_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (sample_tick) begin
          if (tick_cnt == TICK_MID) begin
            // a high line at mid start bit was only a glitch
            state_d = rx_s ? IDLE : DATA;
            tick_d  = '0;
            bit_d   = '0;
          end else begin
            tick_d = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          if (tick_cnt == TICK_LAST) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            if (bit_cnt == BIT_LAST) begin
              state_d = STOP;
              bit_d   = '0;
            end else begin
              bit_d = bit_cnt + 1'b1;
            end
          end else begin
            tick_d = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (sample_tick) begin
          if (tick_cnt == TICK_LAST) begin
            if (rx_s) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = IDLE;
            tick_d  = '0;
            bit_d   = '0;
          end else begin
            tick_d = tick_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with hand-computed expectations.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_tick = 1'b0;
  logic       i_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [7:0] rec[$];
  bit tie_high = 1'b0;
  int div = 0;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .i_rx        (i_rx),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  // sample_tick every 4 clks, or continuously when tied high
  always @(negedge clk) begin
    div = (div + 1) % 4;
    sample_tick = tie_high ? 1'b1 : (div == 0);
  end

  // strobe monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_done) begin
        done_cnt++;
        rec.push_back(rx_data);
      end
      if (frame_err) err_cnt++;
      if (rx_done && frame_err) both_cnt++;
    end
  end

  task automatic send_bit(input logic b, input int n);
    i_rx = b;
    repeat (n) @(negedge clk);
  endtask

  // bad stop: line low past the mid-stop sample, then high for the rest of the bit
  task automatic send_frame(input logic [7:0] d, input bit good_stop, input int cpb);
    send_bit(1'b0, cpb);
    for (int i = 0; i < 8; i++) send_bit(d[i], cpb);
    if (good_stop) send_bit(1'b1, cpb);
    else begin
      send_bit(1'b0, cpb * 5 / 8);
      send_bit(1'b1, cpb - cpb * 5 / 8);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    total++; if (rx_done !== 1'b0) begin bad++; $display("FAIL reset_rx_done got=%b want=0", rx_done); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_rx_busy got=%b want=0", rx_busy); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_glitch;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    i_rx = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_high got=%b want=1", rx_busy); end
    repeat (10) @(negedge clk);
    i_rx = 1'b1;
    repeat (60) @(negedge clk);
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_low got=%b want=0", rx_busy); end
    total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL glitch_done got=%0d want=0", done_cnt - d0); end
    total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL glitch_err got=%0d want=0", err_cnt - e0); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL glitch_rx_data got=%h want=00", rx_data); end
  endtask

  task automatic test_good_frame;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b1, 64);
    repeat (8) @(negedge clk);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL a5_done_count got=%0d want=1", done_cnt - d0); end
    total++;
    if (rec.size() == 0) begin bad++; $display("FAIL a5_strobe_data got=none want=a5"); end
    else if (rec[rec.size()-1] !== 8'hA5) begin bad++; $display("FAIL a5_strobe_data got=%h want=a5", rec[rec.size()-1]); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL a5_rx_data got=%h want=a5", rx_data); end
    total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL a5_frame_err got=%0d want=0", err_cnt - e0); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL a5_busy got=%b want=0", rx_busy); end
  endtask

  task automatic test_frame_err;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h12, 1'b1, 64);
    repeat (8) @(negedge clk);
    send_frame(8'h3C, 1'b0, 64);
    repeat (100) @(negedge clk);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL ferr_done_count got=%0d want=1", done_cnt - d0); end
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL ferr_err_count got=%0d want=1", err_cnt - e0); end
    total++; if (rx_data !== 8'h12) begin bad++; $display("FAIL ferr_rx_data got=%h want=12", rx_data); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL ferr_busy got=%b want=0", rx_busy); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [3];
    int d0, n;
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h81;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, 64);
    repeat (8) @(negedge clk);
    total++; if (done_cnt - d0 != 3) begin bad++; $display("FAIL b2b_done_count got=%0d want=3", done_cnt - d0); end
    n = rec.size();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (n < 3) begin bad++; $display("FAIL b2b_data%0d got=none want=%h", i, exp_b[i]); end
      else if (rec[n-3+i] !== exp_b[i]) begin bad++; $display("FAIL b2b_data%0d got=%h want=%h", i, rec[n-3+i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    // 0x5A: bits 0..2 = 0,1,0; abort halfway through bit 3 (=1)
    send_bit(1'b0, 64);
    send_bit(1'b0, 64);
    send_bit(1'b1, 64);
    send_bit(1'b0, 64);
    send_bit(1'b1, 32);
    #2 rst = 1'b1;
    #1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL midrst_rx_data got=%h want=00", rx_data); end
    total++; if (rx_done !== 1'b0) begin bad++; $display("FAIL midrst_rx_done got=%b want=0", rx_done); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL midrst_frame_err got=%b want=0", frame_err); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL midrst_rx_busy got=%b want=0", rx_busy); end
    i_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    total++; if (done_cnt - d0 != 0 || err_cnt - e0 != 0) begin bad++; $display("FAIL midrst_aborted_strobe got=%0d want=0", (done_cnt - d0) + (err_cnt - e0)); end
    repeat (8) @(negedge clk);
    d0 = done_cnt;
    send_frame(8'hC3, 1'b1, 64);
    repeat (8) @(negedge clk);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL midrst_c3_done got=%0d want=1", done_cnt - d0); end
    total++; if (rx_data !== 8'hC3) begin bad++; $display("FAIL midrst_c3_data got=%h want=c3", rx_data); end
  endtask

  // tick every clk: start detect 3 edges after the line falls, mid start 8
  // ticks later, then 16 ticks per bit; rx_done is seen 155 negedges after
  // the falling negedge.
  task automatic test_tied_tick;
    logic [7:0] d;
    int first_k, pulses;
    logic b;
    d = 8'h01;
    tie_high = 1'b1;
    repeat (4) @(negedge clk);
    first_k = -1;
    pulses = 0;
    for (int k = 0; k < 176; k++) begin
      if (rx_done) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if (k < 16) b = 1'b0;
      else if (k < 144) b = d[k/16 - 1];
      else b = 1'b1;
      i_rx = b;
      @(negedge clk);
    end
    i_rx = 1'b1;
    total++; if (first_k != 155) begin bad++; $display("FAIL tied_done_cycle got=%0d want=155", first_k); end
    total++; if (pulses != 1) begin bad++; $display("FAIL tied_done_pulses got=%0d want=1", pulses); end
    total++; if (rx_data !== 8'h01) begin bad++; $display("FAIL tied_rx_data got=%h want=01", rx_data); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_good_frame();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_tied_tick();
    total++; if (both_cnt != 0) begin bad++; $display("FAIL done_and_err_together got=%0d want=0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side neighbour of the UART transmitter. It deserialises an asynchronous 8N1 serial line into bytes.
- Oversamples the line using a shared baud-generator tick at OVERSAMPLE × baud rate.
- Sits between the board RX pin and the byte consumer, such as a loopback into the TX path or a command decoder.
- Delivers each byte with a one-clock done strobe and flags framing errors.

Parameters:
- OVERSAMPLE, 16, sample_tick pulses per bit period; must be even and ≥ 4.
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sample_tick  input  1  one-clk pulse at OVERSAMPLE × baud rate
- i_rx  input  1  raw serial line; idles high; asynchronous to clk
- rx_data  output  DATA_BITS  last correctly framed byte; held until the next good frame
- rx_done  output  1  one-clk pulse when rx_data is updated
- frame_err  output  1  one-clk pulse when the stop bit samples low
- rx_busy  output  1  high from start-bit detect until return to IDLE

Behaviour:
- Synchroniser:
  - i_rx passes through a 2-flop synchroniser; both flops reset to 1.
  - All decisions use the synchronised value rx_s.
- Reset values: rx_data = 0, rx_done = 0, frame_err = 0, rx_busy = 0, state = IDLE, tick counter = 0, bit counter = 0, shift register = 0.
- Reset mid-frame: the partial frame is discarded and no strobe is produced. After release, the block waits in IDLE for the next falling edge.
- Counters:
  - tick_cnt has width clog2(OVERSAMPLE) and advances only on sample_tick.
  - bit_cnt has width clog2(DATA_BITS).
  - Both clear on every state entry.
- IDLE:
  - rx_busy = 0.
  - rx_s == 0 → START, rx_busy goes to 1, tick_cnt = 0.
- START:
  - On sample_tick with tick_cnt == OVERSAMPLE/2 − 1 (mid start bit):
    - rx_s == 0 → DATA, tick_cnt = 0.
    - rx_s == 1 → false start (glitch) → IDLE. No strobe.
  - Otherwise tick_cnt increments on each sample_tick.
- DATA:
  - On sample_tick with tick_cnt == OVERSAMPLE − 1 (mid data bit):
    - Shift rx_s in at the MSB side, so the first received bit ends at bit 0.
    - tick_cnt wraps to 0.
    - bit_cnt == DATA_BITS − 1 → STOP; else bit_cnt++.
- STOP:
  - On sample_tick with tick_cnt == OVERSAMPLE − 1 (mid stop bit):
    - rx_s == 1 → rx_data = shift register, rx_done = 1 for one clk.
    - rx_s == 0 → frame_err = 1 for one clk, rx_data unchanged.
    - Either outcome → IDLE.
- Latency: rx_done and frame_err are registered. They are high in the clk cycle immediately after the clk edge on which the qualifying sample_tick is seen. rx_busy falls on that same edge.
- Back-to-back frames: returning to IDLE at mid stop bit lets a start bit that immediately follows the stop bit be detected without loss.
- sample_tick held high continuously is legal: the counters advance every clk. The bench uses this for fast simulation.
- Line stuck low (break):
  - Produces frame_err once, then re-detects a start bit because rx_s == 0 in IDLE.
  - This repeats, giving frame_err once per frame time. This is accepted behaviour.
- rx_done and frame_err are never high in the same cycle.

Decomposition:
- Shared package uart_pkg:
  - RX state encoding: IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11. This matches the TX state numbering.
  - OVERSAMPLE default; frame-width constant.
- One sub-module, uart_rx_sync: the 2-flop synchroniser, reset to 1, on clk/rst.
- The FSM, counters and shift register stay in uart_rx.

Test Plan:
- 8N1 frame of 0xA5 at OVERSAMPLE = 16 with sample_tick every 4 clks → exactly one rx_done pulse, rx_data = 0xA5, frame_err never high, rx_busy low after the pulse.
- Low glitch of 5 sample_ticks on an idle line → no rx_done or frame_err, rx_busy returns to 0 at mid start bit, rx_data unchanged (0x00).
- Frame 0x3C with a low stop bit, after a prior good 0x12 → one frame_err pulse, no rx_done, rx_data stays 0x12.
- Back-to-back frames 0x00, 0xFF, 0x81 with zero idle gap → three rx_done pulses with rx_data = 0x00, 0xFF, 0x81 in order.
- rst asserted asynchronously during data bit 3 of 0x5A, then frame 0xC3 → no strobe for the aborted frame, all outputs 0 during reset, then rx_data = 0xC3 with one rx_done.
- sample_tick tied high, frame 0x01 sent at 16 clks per bit → rx_done in the cycle after the mid stop-bit sample, rx_data = 0x01.
